// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths,
// decoded control bundle, bubble constant and ALU operation encodings.
package id_ex_stage_pkg;

   localparam int unsigned DATA_W_DEF  = 32;
   localparam int unsigned REG_AW_DEF  = 5;
   localparam int unsigned ALUOP_W_DEF = 4;
   localparam int unsigned CNT_W_DEF   = 16;

   typedef enum logic [3:0] {
      ALU_AND = 4'h0,
      ALU_OR  = 4'h1,
      ALU_ADD = 4'h2,
      ALU_SUB = 4'h6,
      ALU_SLT = 4'h7,
      ALU_NOR = 4'hC
   } alu_op_e;

   typedef struct packed {
      logic regwrite;
      logic memread;
      logic memwrite;
      logic memtoreg;
      logic alusrc;
      logic regdst;
   } ctrl_t;

   // A bubble carries no side effects: no register write, no memory access.
   localparam ctrl_t CTRL_BUBBLE = '0;

   function automatic ctrl_t pack_ctrl(input logic regwrite, input logic memread,
                                       input logic memwrite, input logic memtoreg,
                                       input logic alusrc, input logic regdst);
      ctrl_t c;
      c.regwrite = regwrite;
      c.memread  = memread;
      c.memwrite = memwrite;
      c.memtoreg = memtoreg;
      c.alusrc   = alusrc;
      c.regdst   = regdst;
      return c;
   endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction in ID forces a one-cycle stall of PC and IF/ID.
module id_ex_stage_hazard_detect
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned REG_AW = REG_AW_DEF
) (
   input  logic              reset,
   input  logic              mem_busy,
   input  logic              id_ex_memread,
   input  logic              id_ex_valid,
   input  logic [REG_AW-1:0] id_ex_rt,
   input  logic [REG_AW-1:0] if_id_rs,
   input  logic [REG_AW-1:0] if_id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   output logic              luh,
   output logic              pc_write,
   output logic              if_id_write
);

   logic rs_match;
   logic rt_match;

   // Hazard decode from registered EX state; $0 never creates a dependency.
   // Reset masks the hazard so the front end keeps advancing while reset is held.
   always_comb begin
      rs_match    = id_uses_rs && (id_ex_rt == if_id_rs);
      rt_match    = id_uses_rt && (id_ex_rt == if_id_rt);
      luh         = !reset && id_ex_memread && id_ex_valid && (id_ex_rt != '0)
                    && (rs_match || rt_match);
      pc_write    = !mem_busy && !luh;
      if_id_write = !mem_busy && !luh;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush, memory-busy
// freeze and a saturating count of inserted load-use bubbles.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned REG_AW  = REG_AW_DEF,
   parameter int unsigned ALUOP_W = ALUOP_W_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [REG_AW-1:0]  if_id_rs,
   input  logic [REG_AW-1:0]  if_id_rt,
   input  logic [REG_AW-1:0]  if_id_rd,
   input  logic               id_uses_rs,
   input  logic               id_uses_rt,
   input  logic [DATA_W-1:0]  id_rd1,
   input  logic [DATA_W-1:0]  id_rd2,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic               id_regwrite,
   input  logic               id_memread,
   input  logic               id_memwrite,
   input  logic               id_memtoreg,
   input  logic               id_alusrc,
   input  logic               id_regdst,
   input  logic [ALUOP_W-1:0] id_aluop,
   input  logic               flush,
   input  logic               mem_busy,
   output logic               pc_write,
   output logic               if_id_write,
   output logic [REG_AW-1:0]  id_ex_rs,
   output logic [REG_AW-1:0]  id_ex_rt,
   output logic [REG_AW-1:0]  id_ex_rd,
   output logic [DATA_W-1:0]  id_ex_rd1,
   output logic [DATA_W-1:0]  id_ex_rd2,
   output logic [DATA_W-1:0]  id_ex_imm,
   output logic               id_ex_regwrite,
   output logic               id_ex_memread,
   output logic               id_ex_memwrite,
   output logic               id_ex_memtoreg,
   output logic               id_ex_alusrc,
   output logic               id_ex_regdst,
   output logic [ALUOP_W-1:0] id_ex_aluop,
   output logic               id_ex_valid,
   output logic [CNT_W-1:0]   bubble_count
);

   ctrl_t               ctrl_q,  ctrl_d;
   logic [REG_AW-1:0]   rs_q,    rs_d;
   logic [REG_AW-1:0]   rt_q,    rt_d;
   logic [REG_AW-1:0]   rd_q,    rd_d;
   logic [DATA_W-1:0]   rd1_q,   rd1_d;
   logic [DATA_W-1:0]   rd2_q,   rd2_d;
   logic [DATA_W-1:0]   imm_q,   imm_d;
   logic [ALUOP_W-1:0]  aluop_q, aluop_d;
   logic                valid_q, valid_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic                luh;

   id_ex_stage_hazard_detect #(
      .REG_AW (REG_AW)
   ) u_hazard (
      .reset         (reset),
      .mem_busy      (mem_busy),
      .id_ex_memread (ctrl_q.memread),
      .id_ex_valid   (valid_q),
      .id_ex_rt      (rt_q),
      .if_id_rs      (if_id_rs),
      .if_id_rt      (if_id_rt),
      .id_uses_rs    (id_uses_rs),
      .id_uses_rt    (id_uses_rt),
      .luh           (luh),
      .pc_write      (pc_write),
      .if_id_write   (if_id_write)
   );

   // Next-state: freeze beats flush, flush beats load-use, otherwise capture ID.
   always_comb begin
      ctrl_d  = ctrl_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rd_d    = rd_q;
      rd1_d   = rd1_q;
      rd2_d   = rd2_q;
      imm_d   = imm_q;
      aluop_d = aluop_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (!mem_busy) begin
         if (flush || luh) begin
            ctrl_d  = CTRL_BUBBLE;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            aluop_d = '0;
            valid_d = 1'b0;
            // A flushed slot is not a load-use bubble, so only luh alone counts.
            if (!flush && (cnt_q != '1)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            ctrl_d  = pack_ctrl(id_regwrite, id_memread, id_memwrite,
                                id_memtoreg, id_alusrc, id_regdst);
            rs_d    = if_id_rs;
            rt_d    = if_id_rt;
            rd_d    = if_id_rd;
            rd1_d   = id_rd1;
            rd2_d   = id_rd2;
            imm_d   = id_imm;
            aluop_d = id_aluop;
            valid_d = 1'b1;
         end
      end
   end

   // Pipeline register and bubble counter; reset overrides every other input.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q  <= CTRL_BUBBLE;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         aluop_q <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         imm_q   <= imm_d;
         aluop_q <= aluop_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output fan-out of the registered state.
   always_comb begin
      id_ex_rs       = rs_q;
      id_ex_rt       = rt_q;
      id_ex_rd       = rd_q;
      id_ex_rd1      = rd1_q;
      id_ex_rd2      = rd2_q;
      id_ex_imm      = imm_q;
      id_ex_regwrite = ctrl_q.regwrite;
      id_ex_memread  = ctrl_q.memread;
      id_ex_memwrite = ctrl_q.memwrite;
      id_ex_memtoreg = ctrl_q.memtoreg;
      id_ex_alusrc   = ctrl_q.alusrc;
      id_ex_regdst   = ctrl_q.regdst;
      id_ex_aluop    = aluop_q;
      id_ex_valid    = valid_q;
      bubble_count   = cnt_q;
   end

endmodule
